// File: rtl/imp_delay_sched.sv
// imp_delay_sched: multi-channel impulse delay scheduler sequenced from one shared tus tick counter
module imp_delay_sched #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 16,
   parameter int WID_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imp,
   input  logic             tus,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [WID_W-1:0] cfg_width,
   input  logic [N_CH-1:0]  ch_en,
   output logic [N_CH-1:0]  o_imp,
   output logic             busy,
   output logic             err_retrig
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [2:0] imp_sr, tus_sr;
   logic imp_rise, tus_rise, tick_sat, done, go;
   logic [CNT_W-1:0] tick, tick_nx;
   logic [CNT_W:0] end_tick, end_nx;
   logic [N_CH-1:0] en_a, qual, hit, o_nx;
   logic [CNT_W-1:0] delay_s [N_CH];
   logic [CNT_W-1:0] delay_a [N_CH];
   logic [WID_W-1:0] width_s [N_CH];
   logic [WID_W-1:0] width_a [N_CH];
   logic [CNT_W:0] stop_s [N_CH];
   logic [CNT_W:0] stop_a [N_CH];

   assign imp_rise = imp_sr[2:1] == 2'b01;
   assign tus_rise = tus_sr[2:1] == 2'b01;
   assign busy = state == RUN;
   assign tick_sat = &tick;
   assign done = {1'b0, tick} >= end_tick || tick_sat;

   // stop tick is one past the last high tick; widened by a bit so it never wraps
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign stop_s[i] = {1'b0, delay_s[i]} + (CNT_W+1)'(width_s[i]);
      assign stop_a[i] = {1'b0, delay_a[i]} + (CNT_W+1)'(width_a[i]);
      assign qual[i] = ch_en[i] && width_s[i] != '0;
      assign hit[i] = en_a[i] && width_a[i] != '0 && tick >= delay_a[i] && {1'b0, tick} < stop_a[i];
   end

   // sequence length is the latest stop tick among channels that will fire
   always_comb begin
      end_nx = '0;
      for (int k = 0; k < N_CH; k++)
         end_nx = qual[k] && stop_s[k] > end_nx ? stop_s[k] : end_nx;
   end

   // next state, tick advance and channel outputs
   always_comb begin
      state_nx = state;
      tick_nx = tick;
      o_nx = '0;
      go = 1'b0;
      if (state == IDLE) begin
         go = imp_rise && |qual;
         state_nx = go ? RUN : IDLE;
         tick_nx = go ? '0 : tick;
      end else begin
         state_nx = done ? IDLE : RUN;
         o_nx = done ? '0 : hit;
         tick_nx = tus_rise && !tick_sat ? tick + 1'b1 : tick;
      end
   end

   // input conditioning, state, tick and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imp_sr <= '0;
         tus_sr <= '0;
         state <= IDLE;
         tick <= '0;
         end_tick <= '0;
         en_a <= '0;
         o_imp <= '0;
         err_retrig <= 1'b0;
      end else begin
         imp_sr <= {imp_sr[1:0], imp};
         tus_sr <= {tus_sr[1:0], tus};
         state <= state_nx;
         tick <= tick_nx;
         o_imp <= o_nx;
         err_retrig <= busy && imp_rise;
         if (go) begin
            end_tick <= end_nx;
            en_a <= ch_en;
         end
      end
   end

   // shadow config takes host writes; active copy snapshots the pre-write shadow on trigger
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_CH; k++) begin
            delay_s[k] <= '0;
            width_s[k] <= '0;
            delay_a[k] <= '0;
            width_a[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (cfg_we && cfg_addr == 3'(k)) begin
               delay_s[k] <= cfg_delay;
               width_s[k] <= cfg_width;
            end
            if (go) begin
               delay_a[k] <= delay_s[k];
               width_a[k] <= width_s[k];
            end
         end
      end
   end
endmodule

// File: tb/tb_imp_delay_sched.sv
// tb_imp_delay_sched: table-driven scoreboard bench for imp_delay_sched
`timescale 1ns/1ps
module tb_imp_delay_sched;
   localparam int N_CH = 4, CNT_W = 4, WID_W = 8;
   localparam int CFG = 0, TRIG = 1, RETRIG = 2, TUS = 3;

   typedef struct {
      int op;
      int a;
      int b;
      int c;
      int n;
      logic [3:0] eo;
      logic eb;
      int ee;
   } vec_t;

   typedef struct {
      logic [3:0] o;
      logic b;
      int e;
   } exp_t;

   logic clk, rst_n, imp, tus, cfg_we;
   logic [2:0] cfg_addr;
   logic [CNT_W-1:0] cfg_delay;
   logic [WID_W-1:0] cfg_width;
   logic [N_CH-1:0] ch_en, o_imp;
   logic busy, err_retrig;

   vec_t tbl[$];
   exp_t sb[$];
   int n_cmp = 0, n_bad = 0, err_seen = 0;

   imp_delay_sched #(.N_CH(N_CH), .CNT_W(CNT_W), .WID_W(WID_W)) dut (
      .clk(clk), .rst_n(rst_n), .imp(imp), .tus(tus), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
      .ch_en(ch_en), .o_imp(o_imp), .busy(busy), .err_retrig(err_retrig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (err_retrig) err_seen++;

   function automatic vec_t mk(input int op, input int a, input int b, input int c, input int n,
                               input logic [3:0] eo, input logic eb, input int ee);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.c = c; v.n = n; v.eo = eo; v.eb = eb; v.ee = ee;
      return v;
   endfunction

   function automatic void cfg(input int ch, input int d, input int w);
      tbl.push_back(mk(CFG, ch, d, w, 0, 4'b0, 1'b0, 0));
   endfunction

   function automatic void trig(input int en, input logic [3:0] eo, input logic eb);
      tbl.push_back(mk(TRIG, en, 0, 0, 0, eo, eb, 0));
   endfunction

   function automatic void tck(input int n, input logic [3:0] eo, input logic eb);
      tbl.push_back(mk(TUS, 0, 0, 0, n, eo, eb, 0));
   endfunction

   task automatic check(input string nm, input logic [3:0] eo, input logic eb, input int ee, input int ge);
      n_cmp++;
      if (o_imp !== eo || busy !== eb || ge != ee) begin
         n_bad++;
         $display("FAIL %s: got o_imp=%b busy=%b err=%0d, want o_imp=%b busy=%b err=%0d",
                  nm, o_imp, busy, ge, eo, eb, ee);
      end
   endtask

   task automatic pulse_imp();
      imp = 1'b1;
      repeat (3) @(negedge clk);
      imp = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_tus();
      tus = 1'b1;
      repeat (3) @(negedge clk);
      tus = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic run_op(input vec_t v, input string nm);
      int e0;
      exp_t x;
      e0 = err_seen;
      if (v.op != CFG) begin
         x.o = v.eo; x.b = v.eb; x.e = v.ee;
         sb.push_back(x);
      end
      case (v.op)
         CFG: begin
            cfg_addr = 3'(v.a);
            cfg_delay = CNT_W'(v.b);
            cfg_width = WID_W'(v.c);
            cfg_we = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0;
         end
         TRIG: begin
            ch_en = N_CH'(v.a);
            pulse_imp();
         end
         RETRIG: pulse_imp();
         default: repeat (v.n) pulse_tus();
      endcase
      if (v.op != CFG) begin
         x = sb.pop_front();
         check(nm, x.o, x.b, x.e, err_seen - e0);
      end
   endtask

   initial begin
      rst_n = 1'b0; imp = 1'b0; tus = 1'b0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_delay = '0; cfg_width = '0; ch_en = '0;
      for (int i = 0; i < 12; i++) begin
         imp = i[1];
         tus = i[0];
         @(negedge clk);
         check("reset", 4'b0, 1'b0, 0, int'(err_retrig));
      end
      imp = 1'b0; tus = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      cfg(0, 5, 3);
      trig(1, 4'b0000, 1);
      tck(4, 4'b0000, 1);
      tck(1, 4'b0001, 1);
      tck(2, 4'b0001, 1);
      tck(1, 4'b0000, 0);
      tck(2, 4'b0000, 0);

      cfg(0, 0, 2); cfg(1, 4, 1); cfg(2, 4, 0); cfg(3, 1, 1);
      trig(7, 4'b0001, 1);
      tck(1, 4'b0001, 1);
      tck(1, 4'b0000, 1);
      tck(1, 4'b0000, 1);
      tck(1, 4'b0010, 1);
      tck(1, 4'b0000, 0);

      cfg(0, 2, 2);
      trig(1, 4'b0000, 1);
      tck(1, 4'b0000, 1);
      tbl.push_back(mk(RETRIG, 0, 0, 0, 0, 4'b0000, 1'b1, 1));
      cfg(0, 7, 2);
      tck(1, 4'b0001, 1);
      tck(1, 4'b0001, 1);
      tck(1, 4'b0000, 0);
      trig(1, 4'b0000, 1);
      tck(6, 4'b0000, 1);
      tck(1, 4'b0001, 1);
      tck(1, 4'b0001, 1);
      tck(1, 4'b0000, 0);

      trig(0, 4'b0000, 0);
      trig(4, 4'b0000, 0);

      cfg(0, 14, 8);
      trig(1, 4'b0000, 1);
      tck(13, 4'b0000, 1);
      tck(1, 4'b0001, 1);
      tck(1, 4'b0000, 0);
      tck(1, 4'b0000, 0);

      for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], $sformatf("vec%0d", i));

      run_op(mk(CFG, 0, 2, 5, 0, 4'b0, 1'b0, 0), "ar_cfg");
      run_op(mk(TRIG, 1, 0, 0, 0, 4'b0000, 1'b1, 0), "ar_trig");
      run_op(mk(TUS, 0, 0, 0, 3, 4'b0001, 1'b1, 0), "ar_tick3");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("ar_async_drop", 4'b0, 1'b0, 0, int'(err_retrig));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(mk(TUS, 0, 0, 0, 2, 4'b0000, 1'b0, 0), "ar_no_resume");
      run_op(mk(TRIG, 1, 0, 0, 0, 4'b0000, 1'b0, 0), "ar_cleared_cfg");
      run_op(mk(CFG, 0, 2, 5, 0, 4'b0, 1'b0, 0), "ar_cfg2");
      run_op(mk(TRIG, 1, 0, 0, 0, 4'b0000, 1'b1, 0), "ar_retrig_ok");
      run_op(mk(TUS, 0, 0, 0, 2, 4'b0001, 1'b1, 0), "ar_tick2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
